// File: rtl/stack_data_memory_if.sv
// Port bundle for stack_data_memory: access request from the datapath and the
// registered read/status returns.
interface stack_data_memory_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              wea;
  logic              err_clr;
  logic [DATA_W-1:0] douta;
  logic [DATA_W-1:0] doutb;
  logic              underflow;
  logic              err;
  logic [ADDR_W-1:0] err_addr;

  modport master (
    output en, addr, din, wea, err_clr,
    input  douta, doutb, underflow, err, err_addr
  );

  modport slave (
    input  en, addr, din, wea, err_clr,
    output douta, doutb, underflow, err, err_addr
  );
endinterface

// File: rtl/stack_data_memory.sv
// Stack-machine data memory: read/write port at top of stack, read-only port
// OFFSET_B words below it, registered outputs, sticky illegal-address capture.
module stack_data_memory #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH_LOG2 = 14,
  parameter int unsigned OFFSET_B   = 1
) (
  input logic                clk,
  input logic                reset_n,
  stack_data_memory_if.slave bus
);

  localparam int unsigned Words = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] OffsetLo = DEPTH_LOG2'(OFFSET_B);

  logic [DATA_W-1:0]     r_mem [Words];
  logic [DATA_W-1:0]     r_douta;
  logic [DATA_W-1:0]     r_doutb;
  logic                  r_underflow;
  logic                  r_err;
  logic [ADDR_W-1:0]     r_err_addr;

  logic [DEPTH_LOG2-1:0] w_alo;
  logic [DEPTH_LOG2-1:0] w_ablo;
  logic                  w_illegal;
  logic                  w_legal;
  logic                  w_write;

  always_comb begin
    w_alo     = bus.addr[DEPTH_LOG2-1:0];
    w_ablo    = w_alo - OffsetLo;
    // Shifting by the full width yields zero, so DEPTH_LOG2 == ADDR_W is never illegal.
    w_illegal = bus.en && ((bus.addr >> DEPTH_LOG2) != '0);
    w_legal   = bus.en && !w_illegal;
    w_write   = w_legal && bus.wea;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[w_alo] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_douta     <= '0;
      r_doutb     <= '0;
      r_underflow <= 1'b0;
    end else if (w_legal) begin
      r_douta     <= bus.wea ? bus.din : r_mem[w_alo];
      r_doutb     <= (bus.wea && (w_ablo == w_alo)) ? bus.din : r_mem[w_ablo];
      r_underflow <= (w_alo < OffsetLo);
    end
  end

  // Clear beats a same-cycle capture; the first error since the last clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (bus.err_clr) begin
      r_err      <= 1'b0;
      r_err_addr <= '0;
    end else if (w_illegal && !r_err) begin
      r_err      <= 1'b1;
      r_err_addr <= bus.addr;
    end
  end

  assign bus.douta     = r_douta;
  assign bus.doutb     = r_doutb;
  assign bus.underflow = r_underflow;
  assign bus.err       = r_err;
  assign bus.err_addr  = r_err_addr;

endmodule

// File: tb/tb_stack_data_memory.sv
// Directed bench for stack_data_memory with default parameters.
module tb_stack_data_memory;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  stack_data_memory_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  stack_data_memory #(
    .DATA_W    (16),
    .ADDR_W    (16),
    .DEPTH_LOG2(14),
    .OFFSET_B  (1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one access, take the edge, sample 1 ns later.
  task automatic cycle(input logic en, input logic wea, input logic [15:0] addr,
                       input logic [15:0] din, input logic clr);
    bus.en      = en;
    bus.wea     = wea;
    bus.addr    = addr;
    bus.din     = din;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    reset_n     = 1'b1;
    bus.en      = 1'b0;
    bus.wea     = 1'b0;
    bus.addr    = '0;
    bus.din     = '0;
    bus.err_clr = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    check("rst_douta", 32'(bus.douta), 32'h0);
    check("rst_doutb", 32'(bus.doutb), 32'h0);
    check("rst_uflow", 32'(bus.underflow), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_erraddr", 32'(bus.err_addr), 32'h0);

    @(posedge clk);
    #1 reset_n = 1'b1;
    cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);  // en low after release

    // Basic write then read
    cycle(1'b1, 1'b1, 16'h0004, 16'h4444, 1'b0);
    check("wr4_douta", 32'(bus.douta), 32'h4444);
    cycle(1'b1, 1'b1, 16'h0005, 16'h1234, 1'b0);
    check("wr5_douta", 32'(bus.douta), 32'h1234);
    check("wr5_doutb", 32'(bus.doutb), 32'h4444);
    cycle(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0);
    check("rd5_douta", 32'(bus.douta), 32'h1234);
    check("rd5_doutb", 32'(bus.doutb), 32'h4444);
    check("rd5_uflow", 32'(bus.underflow), 32'h0);

    // Push sequence
    cycle(1'b1, 1'b1, 16'h0009, 16'hAAAA, 1'b0);
    cycle(1'b1, 1'b1, 16'h000A, 16'hBBBB, 1'b0);
    cycle(1'b1, 1'b0, 16'h000A, 16'h0000, 1'b0);
    check("push_douta", 32'(bus.douta), 32'hBBBB);
    check("push_doutb", 32'(bus.doutb), 32'hAAAA);

    // Port B wrap-around
    cycle(1'b1, 1'b1, 16'h0000, 16'h0F0F, 1'b0);
    cycle(1'b1, 1'b1, 16'h3FFF, 16'h7777, 1'b0);
    cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    check("wrap_douta", 32'(bus.douta), 32'h0F0F);
    check("wrap_doutb", 32'(bus.doutb), 32'h7777);
    check("wrap_uflow", 32'(bus.underflow), 32'h1);
    cycle(1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0);
    check("rd1_uflow", 32'(bus.underflow), 32'h0);
    check("rd1_doutb", 32'(bus.doutb), 32'h0F0F);

    // Illegal addresses: first error wins, writes blocked, outputs hold
    cycle(1'b1, 1'b1, 16'h0003, 16'h3333, 1'b0);
    check("wr3_douta", 32'(bus.douta), 32'h3333);
    cycle(1'b1, 1'b1, 16'h4003, 16'hDEAD, 1'b0);
    check("ill1_err", 32'(bus.err), 32'h1);
    check("ill1_erraddr", 32'(bus.err_addr), 32'h4003);
    check("ill1_douta_hold", 32'(bus.douta), 32'h3333);
    check("ill1_uflow_hold", 32'(bus.underflow), 32'h0);
    cycle(1'b1, 1'b1, 16'h8000, 16'hBEEF, 1'b0);
    check("ill2_err", 32'(bus.err), 32'h1);
    check("ill2_erraddr", 32'(bus.err_addr), 32'h4003);
    cycle(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0);
    check("rd3_douta", 32'(bus.douta), 32'h3333);
    check("rd3_err_sticky", 32'(bus.err), 32'h1);

    // Clear in the same cycle as an illegal write
    cycle(1'b1, 1'b1, 16'hC000, 16'h9999, 1'b1);
    check("clr_err", 32'(bus.err), 32'h0);
    check("clr_erraddr", 32'(bus.err_addr), 32'h0);
    check("clr_douta_hold", 32'(bus.douta), 32'h3333);
    cycle(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
    check("clr_mem0", 32'(bus.douta), 32'h0F0F);
    check("clr_err_stays", 32'(bus.err), 32'h0);

    // Disabled write is ignored and outputs hold
    cycle(1'b0, 1'b1, 16'h0005, 16'h5555, 1'b0);
    check("dis_douta", 32'(bus.douta), 32'h0F0F);
    check("dis_doutb", 32'(bus.doutb), 32'h7777);
    check("dis_uflow", 32'(bus.underflow), 32'h1);
    cycle(1'b0, 1'b0, 16'h4000, 16'h0000, 1'b0);
    check("dis_noerr", 32'(bus.err), 32'h0);
    cycle(1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0);
    check("dis_rd5", 32'(bus.douta), 32'h1234);

    // Asynchronous reset mid-stream
    bus.en   = 1'b1;
    bus.wea  = 1'b1;
    bus.addr = 16'h0006;
    bus.din  = 16'h6666;
    #2 reset_n = 1'b0;
    #1;
    check("arst_douta", 32'(bus.douta), 32'h0);
    check("arst_doutb", 32'(bus.doutb), 32'h0);
    check("arst_uflow", 32'(bus.underflow), 32'h0);
    check("arst_err", 32'(bus.err), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
